control_fsm: RTL and testbench

Multicycle control unit for the 16-bit datapath. It sits directly upstream of the program counter register: it decodes the opcode held in the instruction register and sequences fetch, decode, execute, memory and writeback states. Each cycle it drives the PC's `PCWrite` and `branchCond` inputs and every other datapath enable and mux select. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/cpu_pkg.sv | 75 +++++++
 rtl/control_decode.sv | 89 ++++++++
 rtl/control_fsm.sv | 87 ++++++++
 tb/tb_control_fsm.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared control/datapath codes for the 16-bit multicycle CPU.
// CONTROL_JAL_EN enables the jal opcode and its JAL state.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_J     = 4'd5;
  localparam logic [3:0] OP_JAL   = 4'd6;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_LINK  = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef struct packed {
    logic       PCWrite;
    logic       branchCond;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       illegalOp;
  } ctrl_t;

  function automatic logic op_legal(logic [3:0] op);
`ifdef CONTROL_JAL_EN
    return op <= OP_JAL;
`else
    return op <= OP_J;
`endif
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational output decode: state, opcode, memReady -> control bundle.
// CONTROL_JAL_EN builds the JAL state outputs.
module control_decode
  import cpu_pkg::*;
(
  input  state_t      state_i,
  input  logic [3:0]  opcode_i,
  input  logic        memReady_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.MemRead = 1'b1;
        ctrl_o.ALUSrcB = SRCB_ONE;
        ctrl_o.ALUOp   = ALU_ADD;
        ctrl_o.IRWrite = memReady_i;
        ctrl_o.PCWrite = memReady_i;
      end
      S_DECODE: begin
        ctrl_o.ALUSrcB   = SRCB_BOFF;
        ctrl_o.ALUOp     = ALU_ADD;
        ctrl_o.illegalOp = !op_legal(opcode_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.ALUSrcA = 1'b1;
        ctrl_o.ALUSrcB = SRCB_IMM;
        ctrl_o.ALUOp   = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.MemRead = 1'b1;
        ctrl_o.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.MemtoReg = WB_MDR;
        ctrl_o.RegDst   = DST_RT;
      end
      S_MEM_WRITE: begin
        ctrl_o.MemWrite = 1'b1;
        ctrl_o.IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.ALUSrcA = 1'b1;
        ctrl_o.ALUSrcB = SRCB_B;
        ctrl_o.ALUOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.RegDst   = DST_RD;
        ctrl_o.MemtoReg = WB_ALUOUT;
      end
      S_EXEC_I: begin
        ctrl_o.ALUSrcA = 1'b1;
        ctrl_o.ALUSrcB = SRCB_IMM;
        ctrl_o.ALUOp   = ALU_ADD;
      end
      S_I_WB: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.RegDst   = DST_RT;
        ctrl_o.MemtoReg = WB_ALUOUT;
      end
      S_BRANCH: begin
        ctrl_o.ALUSrcA    = 1'b1;
        ctrl_o.ALUSrcB    = SRCB_B;
        ctrl_o.ALUOp      = ALU_SUB;
        ctrl_o.branchCond = 1'b1;
        ctrl_o.PCSource   = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.PCWrite  = 1'b1;
        ctrl_o.PCSource = PC_JUMP;
      end
`ifdef CONTROL_JAL_EN
      S_JAL: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.RegDst   = DST_LINK;
        ctrl_o.MemtoReg = WB_PC;
        ctrl_o.PCWrite  = 1'b1;
        ctrl_o.PCSource = PC_JUMP;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM: state register, next-state logic, reset gating.
// CONTROL_JAL_EN adds the jal opcode (opcode 6 -> JAL state).
module control_fsm
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       branchCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegalOp,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = S_EXEC_R;
          OP_ADDI:  state_d = S_EXEC_I;
          OP_LW:    state_d = S_MEM_ADDR;
          OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
`ifdef CONTROL_JAL_EN
          OP_JAL:   state_d = S_JAL;
`endif
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (memReady) state_d = S_MEM_WB;
      S_MEM_WRITE: if (memReady) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_EXEC_I:    state_d = S_I_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  control_decode u_decode (
    .state_i    (state_q),
    .opcode_i   (opcode),
    .memReady_i (memReady),
    .ctrl_o     (ctrl)
  );

  // Reset is asynchronous, so enables are masked combinationally too.
  assign PCWrite    = ctrl.PCWrite    & ~reset;
  assign branchCond = ctrl.branchCond & ~reset;
  assign MemRead    = ctrl.MemRead    & ~reset;
  assign MemWrite   = ctrl.MemWrite   & ~reset;
  assign IRWrite    = ctrl.IRWrite    & ~reset;
  assign RegWrite   = ctrl.RegWrite   & ~reset;
  assign PCSource   = ctrl.PCSource;
  assign IorD       = ctrl.IorD;
  assign RegDst     = ctrl.RegDst;
  assign MemtoReg   = ctrl.MemtoReg;
  assign ALUSrcA    = ctrl.ALUSrcA;
  assign ALUSrcB    = ctrl.ALUSrcB;
  assign ALUOp      = ctrl.ALUOp;
  assign illegalOp  = ctrl.illegalOp;
  assign state      = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm against an instruction-path model.
// Honours CONTROL_JAL_EN the same way as the design build.
module tb_control_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       memReady;
  logic       PCWrite, branchCond, IorD, MemRead, MemWrite;
  logic       IRWrite, RegWrite, ALUSrcA, illegalOp;
  logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcB, ALUOp;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  control_fsm dut (
    .clock(clock), .reset(reset), .opcode(opcode),
    .memReady(memReady), .PCWrite(PCWrite),
    .branchCond(branchCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .illegalOp(illegalOp), .state(state)
  );

  always #5 clock = ~clock;

`ifdef CONTROL_JAL_EN
  localparam bit JAL = 1'b1;
`else
  localparam bit JAL = 1'b0;
`endif

  logic [18:0] outs;
  assign outs = {PCWrite, branchCond, PCSource, IorD,
                 MemRead, MemWrite, IRWrite, RegWrite,
                 RegDst, MemtoReg, ALUSrcA, ALUSrcB,
                 ALUOp, illegalOp};

  // Model: current state plus the states left in this instruction.
  int m_state;
  int m_rest[$];

  function automatic logic [18:0] exp_out(
    int st, logic mr, logic [3:0] op, logic rst);
    logic pcw, bc, iord, mrd, mwr, irw, rw, sa, ill;
    logic [1:0] pcs, dst, m2r, sb, aop;
    pcw = 0; bc = 0; iord = 0; mrd = 0; mwr = 0;
    irw = 0; rw = 0; sa = 0; ill = 0;
    pcs = 0; dst = 0; m2r = 0; sb = 0; aop = 0;
    case (st)
      0: begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      1: begin
        sb = 2'b11;
        ill = !(op <= 5 || (JAL && op == 6));
      end
      2: begin sa = 1; sb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 2'b01; end
      5: begin mwr = 1; iord = 1; end
      6: begin sa = 1; aop = 2'b10; end
      7: begin rw = 1; dst = 2'b01; end
      8: begin sa = 1; sb = 2'b10; end
      9: rw = 1;
      10: begin sa = 1; aop = 2'b01; bc = 1; pcs = 2'b01; end
      11: begin pcw = 1; pcs = 2'b10; end
      12: if (JAL) begin
        rw = 1; dst = 2'b10; m2r = 2'b10;
        pcw = 1; pcs = 2'b10;
      end
      default: ;
    endcase
    if (rst) begin
      pcw = 0; bc = 0; mrd = 0; mwr = 0; irw = 0; rw = 0;
    end
    return {pcw, bc, pcs, iord, mrd, mwr, irw, rw,
            dst, m2r, sa, sb, aop, ill};
  endfunction

  task automatic advance(input logic mr);
    if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr)
      return;
    if (m_state == 0) begin
      case (opcode)
        4'd0: m_rest = {1, 6, 7};
        4'd1: m_rest = {1, 8, 9};
        4'd2: m_rest = {1, 2, 3, 4};
        4'd3: m_rest = {1, 2, 5};
        4'd4: m_rest = {1, 10};
        4'd5: m_rest = {1, 11};
        4'd6: if (JAL) m_rest = {1, 12}; else m_rest = {1};
        default: m_rest = {1};
      endcase
    end
    if (m_rest.size() == 0) m_state = 0;
    else m_state = m_rest.pop_front();
  endtask

  task automatic model_reset();
    m_state = 0;
    m_rest.delete();
  endtask

  task automatic drive(input logic mr);
    memReady = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) advance(memReady);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; memReady = 1'b1; opcode = 4'd2;
    model_reset();
    @(negedge clock);
    #1;
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d want=0", state);
    end
    checks++;
    if (outs !== exp_out(0, 1'b1, opcode, 1'b1)) begin
      failures++;
      $display("FAIL reset_outs got=%h want=%h",
               outs, exp_out(0, 1'b1, opcode, 1'b1));
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_lw();
    int seq[$];
    opcode = 4'd2;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1);
      seq.push_back(state);
      checks++;
      if (outs !== exp_out(m_state, 1'b1, opcode, 1'b0)) begin
        failures++;
        $display("FAIL lw_outs cyc=%0d got=%h want=%h", i,
                 outs, exp_out(m_state, 1'b1, opcode, 1'b0));
      end
      checks++;
      if (RegWrite !== (state == 4'd4)) begin
        failures++;
        $display("FAIL lw_regwrite cyc=%0d got=%b st=%0d",
                 i, RegWrite, state);
      end
      if (i < 5) tick();
    end
    checks++;
    if (seq != '{0, 1, 2, 3, 4, 0}) begin
      failures++;
      $display("FAIL lw_seq got=%p want=0,1,2,3,4,0", seq);
    end
  endtask

  task automatic test_sw_wait();
    logic mrs[7] = '{1, 1, 1, 0, 0, 0, 1};
    int nwr = 0;
    opcode = 4'd3;
    for (int i = 0; i < 7; i++) begin
      drive(mrs[i]);
      if (MemWrite) nwr++;
      checks++;
      if (state !== 4'(m_state)
          || outs !== exp_out(m_state, mrs[i], opcode, 1'b0)) begin
        failures++;
        $display("FAIL sw_cycle cyc=%0d st=%0d/%0d out=%h/%h",
                 i, state, m_state, outs,
                 exp_out(m_state, mrs[i], opcode, 1'b0));
      end
      tick();
    end
    checks++;
    if (nwr != 4) begin
      failures++;
      $display("FAIL sw_memwrite got=%0d want=4", nwr);
    end
    #1;
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL sw_exit got=%0d want=0", state);
    end
  endtask

  task automatic test_beq();
    opcode = 4'd4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1);
      checks++;
      if (state !== 4'(m_state)
          || outs !== exp_out(m_state, 1'b1, opcode, 1'b0)) begin
        failures++;
        $display("FAIL beq_cycle cyc=%0d st=%0d/%0d out=%h/%h",
                 i, state, m_state, outs,
                 exp_out(m_state, 1'b1, opcode, 1'b0));
      end
      if (i == 2) begin
        checks++;
        if ({state, branchCond, PCSource, ALUOp, PCWrite}
            !== {4'd10, 1'b1, 2'b01, 2'b01, 1'b0}) begin
          failures++;
          $display("FAIL beq_branch st=%0d bc=%b pcs=%b aop=%b pcw=%b",
                   state, branchCond, PCSource, ALUOp, PCWrite);
        end
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_illegal();
    int nill = 0;
    int nwe = 0;
    opcode = 4'd9;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1);
      nill += illegalOp;
      nwe += PCWrite + IRWrite + RegWrite + MemWrite + branchCond;
      checks++;
      if (state !== 4'(m_state)
          || outs !== exp_out(m_state, 1'b1, opcode, 1'b0)) begin
        failures++;
        $display("FAIL ill_cycle cyc=%0d st=%0d/%0d out=%h/%h",
                 i, state, m_state, outs,
                 exp_out(m_state, 1'b1, opcode, 1'b0));
      end
      if (i < 2) tick();
    end
    checks++;
    if (nill != 1 || nwe != 4) begin
      failures++;
      $display("FAIL ill_counts ill=%0d want=1 we=%0d want=4",
               nill, nwe);
    end
  endtask

  task automatic test_jal();
    bit saw12 = 0;
    bit sawill = 0;
    opcode = 4'd6;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1);
      if (state == 4'd12 && RegWrite && RegDst == 2'b10 && PCWrite)
        saw12 = 1;
      if (state == 4'd1 && illegalOp) sawill = 1;
      checks++;
      if (state !== 4'(m_state)
          || outs !== exp_out(m_state, 1'b1, opcode, 1'b0)) begin
        failures++;
        $display("FAIL jal_cycle cyc=%0d st=%0d/%0d out=%h/%h",
                 i, state, m_state, outs,
                 exp_out(m_state, 1'b1, opcode, 1'b0));
      end
      if (m_state == 0 && i > 0) break;
      tick();
    end
    checks++;
    if (saw12 !== JAL || sawill !== !JAL) begin
      failures++;
      $display("FAIL jal_mode jal=%b saw12=%b sawill=%b",
               JAL, saw12, sawill);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 4'd2;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1);
      tick();
    end
    #1;
    checks++;
    if (state !== 4'd3) begin
      failures++;
      $display("FAIL rmid_pre got=%0d want=3", state);
    end
    memReady = 1'b1;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (state !== 4'd0 || RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL rmid_async st=%0d rw=%b want 0,0",
               state, RegWrite);
    end
    @(posedge clock);
    #1;
    checks++;
    if (state !== 4'd0 || RegWrite !== 1'b0
        || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      failures++;
      $display("FAIL rmid_hold st=%0d rw=%b irw=%b pcw=%b",
               state, RegWrite, IRWrite, PCWrite);
    end
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1);
    checks++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      failures++;
      $display("FAIL rmid_fetch irw=%b pcw=%b want 1,1",
               IRWrite, PCWrite);
    end
    tick();
    #1;
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL rmid_decode got=%0d want=1", state);
    end
  endtask

  task automatic test_random();
    logic mr;
    for (int i = 0; i < 400; i++) begin
      if (m_state == 0) opcode = 4'($urandom_range(0, 15));
      mr = ($urandom_range(0, 9) < 7);
      drive(mr);
      checks++;
      if (state !== 4'(m_state)
          || outs !== exp_out(m_state, mr, opcode, 1'b0)) begin
        failures++;
        $display("FAIL rnd cyc=%0d op=%0d st=%0d/%0d out=%h/%h",
                 i, opcode, state, m_state, outs,
                 exp_out(m_state, mr, opcode, 1'b0));
      end
      checks++;
      if (PCWrite && branchCond) begin
        failures++;
        $display("FAIL rnd_pc_excl cyc=%0d pcw=1 bc=1 want !both", i);
      end
      tick();
    end
  endtask

  task automatic finish_to_fetch();
    for (int i = 0; i < 20 && m_state != 0; i++) begin
      drive(1'b1);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    memReady = 1'b0;
    opcode = 4'd0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_jal();
    finish_to_fetch();
    test_reset_mid();
    finish_to_fetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
